uart_tx_wr_frontend: RTL and testbench

// - Core-facing write front end of the UART TX path, running in the FIFO write clock domain.
// - Accepts one MMIO store of 1/2/4/8 bytes from the RV64 core.
// - Splits the store into byte pushes to uart_fifo_wr / FIFO memory, least-significant byte first.
// - Stalls the core until every byte has been pushed.
// - Honours the registered full flag. Enforces push spacing so the flag's one-cycle lag cannot overflow the FIFO.

---
 rtl/uart_tx_wr_frontend_pkg.sv | 32 +++
 rtl/uart_tx_wr_frontend_if.sv | 24 ++
 rtl/uart_tx_wr_frontend.sv | 148 ++++++++++++++
 tb/tb_uart_tx_wr_frontend.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/uart_tx_wr_frontend_pkg.sv
// Shared types and constants for the UART TX write front end.
// The CR state exists only when UART_TX_WR_LF2CRLF_EN is defined.
package uart_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } wr_size_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PUSH = 3'd1,
        ST_GAP  = 3'd2,
`ifdef UART_TX_WR_LF2CRLF_EN
        ST_CR   = 3'd3,
`endif
        ST_DONE = 3'd4
    } wr_fe_state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Sizes wider than the store bus are clamped to the bus width in bytes.
    function automatic int unsigned storeBytes(input wr_size_e size, input int unsigned maxBytes);
        int unsigned n;
        n = 32'd1 << size;
        return (n > maxBytes) ? maxBytes : n;
    endfunction

endpackage

// File: rtl/uart_tx_wr_frontend_if.sv
// Core-store and FIFO-push signal bundle for the UART TX write front end.
interface uart_tx_wr_frontend_if #(
    parameter int DATA_WIDTH = 64,
    parameter int BYTE_W     = 8
);
    logic                  i_wr_req;
    logic [DATA_WIDTH-1:0] i_wr_data;
    logic [1:0]            i_wr_size;
    logic                  i_fifo_full;
    logic                  o_wr_stall;
    logic                  o_fifo_winc;
    logic [BYTE_W-1:0]     o_fifo_wdata;
    logic                  o_busy;

    modport master (
        output i_wr_req, i_wr_data, i_wr_size, i_fifo_full,
        input  o_wr_stall, o_fifo_winc, o_fifo_wdata, o_busy
    );

    modport slave (
        input  i_wr_req, i_wr_data, i_wr_size, i_fifo_full,
        output o_wr_stall, o_fifo_winc, o_fifo_wdata, o_busy
    );
endinterface

// File: rtl/uart_tx_wr_frontend.sv
// Splits one core MMIO store into spaced byte pushes to the UART TX FIFO, LSB first.
// Optional macro UART_TX_WR_LF2CRLF_EN inserts a CR push ahead of every LF byte.
module uart_tx_wr_frontend
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int BYTE_W     = 8
) (
    input  logic                   i_fifo_wr_clk,
    input  logic                   i_fifo_wr_rst,
    uart_tx_wr_frontend_if.slave   bus
);

    localparam int NB    = DATA_WIDTH / BYTE_W;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    wr_fe_state_e                r_state;
    wr_fe_state_e                w_next;
    logic [NB-1:0][BYTE_W-1:0]   r_data;
    logic [IDX_W-1:0]            r_idx;
    logic [IDX_W-1:0]            r_last;
    logic [BYTE_W-1:0]           w_curByte;
    logic                        w_lastByte;
    wr_size_e                    w_size;
`ifdef UART_TX_WR_LF2CRLF_EN
    logic                        r_crDone;
`endif

    assign w_size     = wr_size_e'(bus.i_wr_size);
    assign w_curByte  = r_data[r_idx];
    assign w_lastByte = (r_idx == r_last);

    always_ff @(posedge i_fifo_wr_clk or posedge i_fifo_wr_rst) begin
        if (i_fifo_wr_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // GAP after every push gives the registered full flag time to catch up.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_wr_req) begin
                    w_next = ST_PUSH;
`ifdef UART_TX_WR_LF2CRLF_EN
                    if (bus.i_wr_data[BYTE_W-1:0] == ASCII_LF) begin
                        w_next = ST_CR;
                    end
`endif
                end
            end
            ST_PUSH: begin
                if (!bus.i_fifo_full) begin
                    w_next = w_lastByte ? ST_DONE : ST_GAP;
                end
            end
            ST_GAP: begin
                w_next = ST_PUSH;
`ifdef UART_TX_WR_LF2CRLF_EN
                if ((w_curByte == ASCII_LF) && !r_crDone) begin
                    w_next = ST_CR;
                end
`endif
            end
`ifdef UART_TX_WR_LF2CRLF_EN
            ST_CR: begin
                if (!bus.i_fifo_full) begin
                    w_next = ST_GAP;
                end
            end
`endif
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.o_fifo_winc  = 1'b0;
        bus.o_fifo_wdata = '0;
        bus.o_wr_stall   = bus.i_wr_req && (r_state != ST_DONE);
        bus.o_busy       = (r_state != ST_IDLE);
        case (r_state)
            ST_PUSH: begin
                bus.o_fifo_winc  = !bus.i_fifo_full;
                bus.o_fifo_wdata = w_curByte;
            end
`ifdef UART_TX_WR_LF2CRLF_EN
            ST_CR: begin
                bus.o_fifo_winc  = !bus.i_fifo_full;
                bus.o_fifo_wdata = ASCII_CR;
            end
`endif
            default: begin
                bus.o_fifo_winc  = 1'b0;
                bus.o_fifo_wdata = '0;
            end
        endcase
    end

    // The byte index stops at the last byte so it never wraps past N-1.
    always_ff @(posedge i_fifo_wr_clk or posedge i_fifo_wr_rst) begin
        if (i_fifo_wr_rst) begin
            r_data   <= '0;
            r_idx    <= '0;
            r_last   <= '0;
`ifdef UART_TX_WR_LF2CRLF_EN
            r_crDone <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_wr_req) begin
                        r_data   <= bus.i_wr_data;
                        r_idx    <= '0;
                        r_last   <= IDX_W'(storeBytes(w_size, NB) - 1);
`ifdef UART_TX_WR_LF2CRLF_EN
                        r_crDone <= 1'b0;
`endif
                    end
                end
                ST_PUSH: begin
                    if (!bus.i_fifo_full) begin
                        if (!w_lastByte) begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
`ifdef UART_TX_WR_LF2CRLF_EN
                        r_crDone <= 1'b0;
`endif
                    end
                end
`ifdef UART_TX_WR_LF2CRLF_EN
                ST_CR: begin
                    if (!bus.i_fifo_full) begin
                        r_crDone <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_wr_frontend.sv
// Directed self-checking bench for uart_tx_wr_frontend (both UART_TX_WR_LF2CRLF_EN builds).
module tb_uart_tx_wr_frontend;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    uart_tx_wr_frontend_if #(.DATA_WIDTH(64), .BYTE_W(8)) bus ();

    uart_tx_wr_frontend #(.DATA_WIDTH(64), .BYTE_W(8)) dut (
        .i_fifo_wr_clk (clk),
        .i_fifo_wr_rst (rst),
        .bus           (bus)
    );

    task automatic applyStimulus(input logic req, input logic [1:0] size,
                                 input logic [63:0] data, input logic full);
        bus.i_wr_req    = req;
        bus.i_wr_size   = size;
        bus.i_wr_data   = data;
        bus.i_fifo_full = full;
        #1;
    endtask

    task automatic setFull(input logic full);
        bus.i_fifo_full = full;
        #1;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic winc, input logic [7:0] wdata,
                               input logic stall, input logic busy);
        logic [10:0] obs;
        logic [10:0] exp;
        obs = {bus.o_fifo_winc, bus.o_fifo_wdata, bus.o_wr_stall, bus.o_busy};
        exp = {winc, wdata, stall, busy};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("[TB] FAIL %s observed winc=%b wdata=%h stall=%b busy=%b expected winc=%b wdata=%h stall=%b busy=%b",
                     tag, obs[10], obs[9:2], obs[1], obs[0], exp[10], exp[9:2], exp[1], exp[0]);
            $error("[TB] comparison %s", tag);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, SZ_B, 64'h0, 1'b0);
        #11;
        checkOutput("reset_idle", 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, SZ_D, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        checkOutput("reset_stall_follows_req", 1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, SZ_B, 64'h0, 1'b0);
        stepCycle();
        stepCycle();
        rst = 1'b0;
        stepCycle();
        checkOutput("post_reset_idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // Byte store
        applyStimulus(1'b1, SZ_B, 64'h41, 1'b0);
        checkOutput("byte_c0", 1'b0, 8'h00, 1'b1, 1'b0);
        stepCycle();
        checkOutput("byte_c1", 1'b1, 8'h41, 1'b1, 1'b1);
        stepCycle();
        checkOutput("byte_c2", 1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, SZ_B, 64'h0, 1'b0);
        stepCycle();
        checkOutput("byte_c3", 1'b0, 8'h00, 1'b0, 1'b0);

        // Double store
        applyStimulus(1'b1, SZ_D, 64'h0807_0605_0403_0201, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            stepCycle();
            if (k == 16)
                checkOutput($sformatf("dbl_c%0d", k), 1'b0, 8'h00, 1'b0, 1'b1);
            else if (k % 2 == 1)
                checkOutput($sformatf("dbl_c%0d", k), 1'b1, 8'((k + 1) / 2), 1'b1, 1'b1);
            else
                checkOutput($sformatf("dbl_c%0d", k), 1'b0, 8'h00, 1'b1, 1'b1);
        end
        applyStimulus(1'b0, SZ_B, 64'h0, 1'b0);
        stepCycle();
        checkOutput("dbl_idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // Half store with backpressure on the second byte
        applyStimulus(1'b1, SZ_H, 64'h0201, 1'b0);
        stepCycle();
        checkOutput("bp_c1", 1'b1, 8'h01, 1'b1, 1'b1);
        stepCycle();
        checkOutput("bp_c2", 1'b0, 8'h00, 1'b1, 1'b1);
        setFull(1'b1);
        for (int k = 3; k <= 7; k++) begin
            stepCycle();
            checkOutput($sformatf("bp_full_c%0d", k), 1'b0, 8'h02, 1'b1, 1'b1);
        end
        stepCycle();
        setFull(1'b0);
        checkOutput("bp_resume_c8", 1'b1, 8'h02, 1'b1, 1'b1);
        stepCycle();
        checkOutput("bp_done_c9", 1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, SZ_B, 64'h0, 1'b0);
        stepCycle();
        checkOutput("bp_idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset after three bytes of a double store
        applyStimulus(1'b1, SZ_D, 64'h1817_1615_1413_1211, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            stepCycle();
        end
        checkOutput("rstmid_third_push", 1'b1, 8'h13, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstmid_immediate", 1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, SZ_B, 64'h0, 1'b0);
        stepCycle();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            stepCycle();
            checkOutput($sformatf("rstmid_quiet%0d", k), 1'b0, 8'h00, 1'b0, 1'b0);
        end

        // Flush: request dropped after first byte of a word store
        applyStimulus(1'b1, SZ_W, 64'h4433_2211, 1'b0);
        stepCycle();
        checkOutput("flush_c1", 1'b1, 8'h11, 1'b1, 1'b1);
        stepCycle();
        applyStimulus(1'b0, SZ_B, 64'hDEAD_BEEF, 1'b0);
        checkOutput("flush_c2", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 3; k <= 8; k++) begin
            stepCycle();
            if (k == 8)
                checkOutput("flush_done", 1'b0, 8'h00, 1'b0, 1'b1);
            else if (k % 2 == 1)
                checkOutput($sformatf("flush_c%0d", k), 1'b1, 8'h11 * 8'((k + 1) / 2), 1'b0, 1'b1);
            else
                checkOutput($sformatf("flush_c%0d", k), 1'b0, 8'h00, 1'b0, 1'b1);
        end
        stepCycle();
        checkOutput("flush_idle1", 1'b0, 8'h00, 1'b0, 1'b0);
        stepCycle();
        checkOutput("flush_idle2", 1'b0, 8'h00, 1'b0, 1'b0);

        // Line feed byte store
        applyStimulus(1'b1, SZ_B, 64'h0A, 1'b0);
        stepCycle();
`ifdef UART_TX_WR_LF2CRLF_EN
        checkOutput("lf_cr_push", 1'b1, 8'h0D, 1'b1, 1'b1);
        stepCycle();
        checkOutput("lf_gap", 1'b0, 8'h00, 1'b1, 1'b1);
        stepCycle();
        checkOutput("lf_push", 1'b1, 8'h0A, 1'b1, 1'b1);
        stepCycle();
        checkOutput("lf_done", 1'b0, 8'h00, 1'b0, 1'b1);
`else
        checkOutput("lf_push", 1'b1, 8'h0A, 1'b1, 1'b1);
        stepCycle();
        checkOutput("lf_done", 1'b0, 8'h00, 1'b0, 1'b1);
`endif
        applyStimulus(1'b0, SZ_B, 64'h0, 1'b0);
        stepCycle();
        checkOutput("lf_idle", 1'b0, 8'h00, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
